// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS BCD stopwatch with run/lap/pause/full sequencing
// Count, lap register and display are packed as {mt, mo, st, so} nibbles.
module stopwatch_bcd #(
  parameter int PRESCALE = 1,
  parameter int PW       = 4,
  parameter bit ROLLOVER = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       reset_sw,
  output logic [3:0] disp_mt,
  output logic [3:0] disp_mo,
  output logic [3:0] disp_st,
  output logic [3:0] disp_so,
  output logic [2:0] state,
  output logic       min_pulse,
  output logic       wrap
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LAP   = 3'd2,
    S_PAUSE = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  state_t        cur, nxt;
  logic [15:0]   cnt, cnt_n;
  logic [15:0]   lap_q, lap_n;
  logic [15:0]   disp_q, disp_n;
  logic [PW-1:0] presc, presc_n;
  logic          min_q, min_n;
  logic          wrap_q, wrap_n;
  logic          count_en, tick_en, step, at_max;

  always_ff @(posedge clk) begin
    if (clear) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    cnt_n    = cnt;
    lap_n    = lap_q;
    presc_n  = presc;
    min_n    = 1'b0;
    wrap_n   = 1'b0;
    count_en = (cur == S_RUN) || (cur == S_LAP);
    tick_en  = count_en && tick;
    step     = tick_en && (presc == PMAX);
    at_max   = (cnt == 16'h9959);

    if (tick_en) presc_n = step ? '0 : presc + PW'(1);

    // Without rollover the count saturates at 99:59 instead of wrapping.
    if (step && (ROLLOVER || !at_max)) begin
      min_n  = (cnt[7:0] == 8'h59);
      wrap_n = at_max;
      if (cnt[3:0] != 4'd9) begin
        cnt_n[3:0] = cnt[3:0] + 4'd1;
      end else begin
        cnt_n[3:0] = 4'd0;
        if (cnt[7:4] != 4'd5) begin
          cnt_n[7:4] = cnt[7:4] + 4'd1;
        end else begin
          cnt_n[7:4] = 4'd0;
          if (cnt[11:8] != 4'd9) begin
            cnt_n[11:8] = cnt[11:8] + 4'd1;
          end else begin
            cnt_n[11:8]  = 4'd0;
            cnt_n[15:12] = (cnt[15:12] == 4'd9) ? 4'd0 : cnt[15:12] + 4'd1;
          end
        end
      end
    end

    case (cur)
      S_IDLE: if (start_stop) nxt = S_RUN;
      S_RUN: begin
        if (start_stop) begin
          nxt = S_PAUSE;
        end else if (lap) begin
          nxt   = S_LAP;
          lap_n = cnt_n;
        end else if (step && at_max && !ROLLOVER) begin
          nxt = S_FULL;
        end
      end
      S_LAP: begin
        if (start_stop) nxt = S_PAUSE;
        else if (lap)   nxt = S_RUN;
      end
      S_PAUSE: begin
        if (reset_sw) begin
          nxt     = S_IDLE;
          cnt_n   = '0;
          presc_n = '0;
        end else if (start_stop) begin
          nxt = S_RUN;
        end
      end
      S_FULL: begin
        if (reset_sw) begin
          nxt     = S_IDLE;
          cnt_n   = '0;
          presc_n = '0;
        end
      end
      default: nxt = S_IDLE;
    endcase

    disp_n = (nxt == S_LAP) ? lap_n : cnt_n;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt    <= '0;
      lap_q  <= '0;
      disp_q <= '0;
      presc  <= '0;
      min_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      lap_q  <= lap_n;
      disp_q <= disp_n;
      presc  <= presc_n;
      min_q  <= min_n;
      wrap_q <= wrap_n;
    end
  end

  assign state = cur;
  assign {disp_mt, disp_mo, disp_st, disp_so} = disp_q;
  assign min_pulse = min_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - three stopwatch configurations against a seconds-count model
// dut0: PRESCALE=1 ROLLOVER=1, dut1: PRESCALE=1 ROLLOVER=0, dut2: PRESCALE=3 ROLLOVER=1
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic clear = 1'b0, tick = 1'b0, ss = 1'b0, lp = 1'b0, rs = 1'b0;
  logic [3:0] mt [3];
  logic [3:0] mo [3];
  logic [3:0] sd [3];
  logic [3:0] so [3];
  logic [2:0] sv [3];
  logic       mp [3];
  logic       wr [3];
  logic [20:0] obs [3];

  int nvec = 0;
  int nfail = 0;

  int m_state [3] = '{0, 0, 0};
  int m_secs  [3] = '{0, 0, 0};
  int m_lap   [3] = '{0, 0, 0};
  int m_pc    [3] = '{0, 0, 0};
  int m_disp  [3] = '{0, 0, 0};
  bit m_min   [3] = '{0, 0, 0};
  bit m_wrap  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  stopwatch_bcd #(.PRESCALE(1), .PW(4), .ROLLOVER(1'b1)) u0 (
    .clk(clk), .clear(clear), .tick(tick), .start_stop(ss), .lap(lp), .reset_sw(rs),
    .disp_mt(mt[0]), .disp_mo(mo[0]), .disp_st(sd[0]), .disp_so(so[0]),
    .state(sv[0]), .min_pulse(mp[0]), .wrap(wr[0]));
  stopwatch_bcd #(.PRESCALE(1), .PW(4), .ROLLOVER(1'b0)) u1 (
    .clk(clk), .clear(clear), .tick(tick), .start_stop(ss), .lap(lp), .reset_sw(rs),
    .disp_mt(mt[1]), .disp_mo(mo[1]), .disp_st(sd[1]), .disp_so(so[1]),
    .state(sv[1]), .min_pulse(mp[1]), .wrap(wr[1]));
  stopwatch_bcd #(.PRESCALE(3), .PW(4), .ROLLOVER(1'b1)) u2 (
    .clk(clk), .clear(clear), .tick(tick), .start_stop(ss), .lap(lp), .reset_sw(rs),
    .disp_mt(mt[2]), .disp_mo(mo[2]), .disp_st(sd[2]), .disp_so(so[2]),
    .state(sv[2]), .min_pulse(mp[2]), .wrap(wr[2]));

  assign obs[0] = {sv[0], mt[0], mo[0], sd[0], so[0], mp[0], wr[0]};
  assign obs[1] = {sv[1], mt[1], mo[1], sd[1], so[1], mp[1], wr[1]};
  assign obs[2] = {sv[2], mt[2], mo[2], sd[2], so[2], mp[2], wr[2]};

  function automatic int pre_of(int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic bit roll_of(int k);
    return (k != 1);
  endfunction

  function automatic logic [20:0] exp_vec(int k);
    int d;
    d = m_disp[k];
    return {3'(m_state[k]), 4'(d / 600), 4'((d / 60) % 10), 4'((d % 60) / 10), 4'(d % 10),
            m_min[k], m_wrap[k]};
  endfunction

  // Reference: total elapsed seconds 0..5999, states IDLE=0 RUN=1 LAP=2 PAUSE=3 FULL=4.
  task automatic model_edge(input bit c, input bit t, input bit s, input bit l, input bit r);
    for (int k = 0; k < 3; k++) begin
      int ns;
      int nsec;
      bit adv;
      bit hit;
      if (c) begin
        m_state[k] = 0; m_secs[k] = 0; m_lap[k] = 0; m_pc[k] = 0;
        m_disp[k] = 0; m_min[k] = 0; m_wrap[k] = 0;
      end else begin
        ns = m_state[k]; nsec = m_secs[k]; adv = 0; hit = 0;
        m_min[k] = 0; m_wrap[k] = 0;
        if ((ns == 1 || ns == 2) && t) begin
          m_pc[k]++;
          if (m_pc[k] == pre_of(k)) begin
            m_pc[k] = 0;
            adv = 1;
          end
        end
        if (adv) begin
          if (nsec == 5999) begin
            if (roll_of(k)) begin
              nsec = 0; m_wrap[k] = 1; m_min[k] = 1;
            end else begin
              hit = 1;
            end
          end else begin
            nsec++;
            if (nsec % 60 == 0) m_min[k] = 1;
          end
        end
        case (m_state[k])
          0: if (s) ns = 1;
          1: begin
            if (s) ns = 3;
            else if (l) begin ns = 2; m_lap[k] = nsec; end
            else if (hit) ns = 4;
          end
          2: if (s) ns = 3; else if (l) ns = 1;
          3: begin
            if (r) begin ns = 0; nsec = 0; m_pc[k] = 0; end
            else if (s) ns = 1;
          end
          4: if (r) begin ns = 0; nsec = 0; m_pc[k] = 0; end
          default: ns = 0;
        endcase
        m_state[k] = ns;
        m_secs[k]  = nsec;
        m_disp[k]  = (ns == 2) ? m_lap[k] : nsec;
      end
    end
  endtask

  task automatic step(input bit c, input bit t, input bit s, input bit l, input bit r);
    clear = c; tick = t; ss = s; lp = l; rs = r;
    @(posedge clk);
    model_edge(c, t, s, l, r);
    #1;
    clear = 0; tick = 0; ss = 0; lp = 0; rs = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (obs[k] !== 21'd0) begin
        nfail++;
        $display("FAIL reset dut%0d: got %h expected %h", k, obs[k], 21'd0);
      end
    end
  endtask

  task automatic test_clear_mid_run();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (754) step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[0][20:2] !== {3'd1, 16'h1234}) begin
      nfail++;
      $display("FAIL clear_pre dut0: got %h expected %h", obs[0][20:2], {3'd1, 16'h1234});
    end
    step(1, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nfail++;
        $display("FAIL clear_mid dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
      end
    end
    nvec++;
    if (obs[0] !== 21'd0) begin
      nfail++;
      $display("FAIL clear_zero dut0: got %h expected %h", obs[0], 21'd0);
    end
  endtask

  task automatic test_minute();
    int pulses;
    pulses = 0;
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0, 0, 0);
      if (mp[0] === 1'b1) begin
        pulses++;
        nvec++;
        if (obs[0][9:2] !== 8'h00) begin
          nfail++;
          $display("FAIL min_align dut0: got ss %h expected %h", obs[0][9:2], 8'h00);
        end
      end
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nfail++;
          $display("FAIL minute dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
        end
      end
    end
    step(0, 0, 0, 0, 0);
    if (mp[0] === 1'b1) pulses++;
    nvec++;
    if (obs[0][17:2] !== 16'h0100 || pulses != 1) begin
      nfail++;
      $display("FAIL minute_end dut0: got %h pulses %0d expected 0100 pulses 1", obs[0][17:2], pulses);
    end
  endtask

  task automatic test_lap();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (obs[0][20:2] !== {3'd2, 16'h0007}) begin
        nfail++;
        $display("FAIL lap_hold dut0: got %h expected %h", obs[0][20:2], {3'd2, 16'h0007});
      end
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nfail++;
          $display("FAIL lap dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
        end
      end
      if (i < 5) step(0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0);
    nvec++;
    if (obs[0][20:2] !== {3'd1, 16'h0012}) begin
      nfail++;
      $display("FAIL lap_release dut0: got %h expected %h", obs[0][20:2], {3'd1, 16'h0012});
    end
  endtask

  task automatic test_pause_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    nvec++;
    if (obs[0][20:2] !== {3'd3, 16'h0004}) begin
      nfail++;
      $display("FAIL pause_tick dut0: got %h expected %h", obs[0][20:2], {3'd3, 16'h0004});
    end
    step(0, 0, 1, 0, 1);
    nvec++;
    if (obs[0][20:2] !== {3'd0, 16'h0000}) begin
      nfail++;
      $display("FAIL reset_sw dut0: got %h expected %h", obs[0][20:2], {3'd0, 16'h0000});
    end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nfail++;
        $display("FAIL pause_reset dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_wrap_full();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5999; i++) begin
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nfail++;
          $display("FAIL count dut%0d tick %0d: got %h expected %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    nvec++;
    if (obs[0][17:2] !== 16'h9959 || obs[1][17:2] !== 16'h9959) begin
      nfail++;
      $display("FAIL at_max: got %h/%h expected 9959", obs[0][17:2], obs[1][17:2]);
    end
    step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[0] !== {3'd1, 16'h0000, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL wrap dut0: got %h expected %h", obs[0], {3'd1, 16'h0000, 1'b1, 1'b1});
    end
    nvec++;
    if (obs[1] !== {3'd4, 16'h9959, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL full dut1: got %h expected %h", obs[1], {3'd4, 16'h9959, 1'b0, 1'b0});
    end
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[1] !== {3'd4, 16'h9959, 1'b0, 1'b0} || wr[0] !== 1'b0) begin
      nfail++;
      $display("FAIL full_hold: got %h wrap0 %b expected %h wrap0 0", obs[1], wr[0],
               {3'd4, 16'h9959, 1'b0, 1'b0});
    end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (obs[k] !== exp_vec(k)) begin
        nfail++;
        $display("FAIL wrap_full dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_prescale();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (9) step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[2][17:2] !== 16'h0003) begin
      nfail++;
      $display("FAIL prescale9 dut2: got %h expected %h", obs[2][17:2], 16'h0003);
    end
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[2][20:2] !== {3'd1, 16'h0004}) begin
      nfail++;
      $display("FAIL prescale_resume dut2: got %h expected %h", obs[2][20:2], {3'd1, 16'h0004});
    end
    step(0, 1, 0, 0, 0);
    nvec++;
    if (obs[2][17:2] !== 16'h0004) begin
      nfail++;
      $display("FAIL prescale_next dut2: got %h expected %h", obs[2][17:2], 16'h0004);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 19) == 0));
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nfail++;
          $display("FAIL random dut%0d cycle %0d: got %h expected %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_clear_mid_run();
    test_minute();
    test_lap();
    test_pause_reset();
    test_wrap_full();
    test_prescale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
